// File: rtl/spi_pkg.sv
// Shared widths, field layout and FSM encoding for the tracking-frame SPI master.
// frame_t mirrors the camera-side packer: x in the MSBs, then y, then etc.
package spi_pkg;

  localparam int FRAME_W = 32;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int ETC_W   = 13;
  localparam int X_LSB   = 22;
  localparam int Y_LSB   = 13;
  localparam int ETC_LSB = 0;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ETC_W-1:0] etc;
  } frame_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  function automatic frame_t unpack_frame(input logic [FRAME_W-1:0] raw);
    frame_t f;
    f.x   = raw[X_LSB +: X_W];
    f.y   = raw[Y_LSB +: Y_W];
    f.etc = raw[ETC_LSB +: ETC_W];
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// Request/result and SPI pin bundle between the frame master and its users.
// The master modport is the SPI controller side; slave is the consumer/pin side.
interface spi_frame_master_if;
  import spi_pkg::*;

  logic               start;
  logic [FRAME_W-1:0] tx_data;
  logic               busy;
  logic               rx_valid;
  logic [X_W-1:0]     rx_x;
  logic [Y_W-1:0]     rx_y;
  logic [ETC_W-1:0]   rx_etc;
  logic [FRAME_W-1:0] rx_frame;
  logic               sclk;
  logic               mosi;
  logic               miso;
  logic               cs;

  modport master (
    input  start, tx_data, miso,
    output busy, rx_valid, rx_x, rx_y, rx_etc, rx_frame, sclk, mosi, cs
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, rx_valid, rx_x, rx_y, rx_etc, rx_frame, sclk, mosi, cs
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Mode-0 SPI clock generator: toggles sclk every CLK_DIV clk cycles while enabled
// and flags, one cycle ahead of the registered edge, which edge is being made.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = enable && (div_cnt == DIV_LAST);
  assign rise_stb = wrap && !sclk;
  assign fall_stb = wrap && sclk;

  // Dropping enable parks sclk low and restarts the half-period from zero.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master that exchanges one 32-bit frame per start and unpacks the
// received telemetry into x/y/etc fields with a single-cycle valid strobe.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4
) (
  input logic                clk,
  input logic                reset,
  spi_frame_master_if.master bus
);

  // SETUP counts one extra cycle so the first rise lands after the acceptance cycle.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
  localparam logic [5:0] FRAME_BITS = 6'(FRAME_W);

  state_t             state;
  logic [7:0]         cnt;
  logic [5:0]         bit_cnt;
  logic [FRAME_W-1:0] tx_shift;
  logic [FRAME_W-1:0] rx_shift;
  logic               cs_q;
  logic               mosi_q;
  logic               busy_q;
  logic               rx_valid_q;
  logic [FRAME_W-1:0] rx_frame_q;
  frame_t             rx_fields_q;
  logic               sclk_w;
  logic               rise_stb;
  logic               fall_stb;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (state == XFER),
    .sclk     (sclk_w),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // tx_shift holds the bits still to send; bit 31 of tx_data goes straight to mosi.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_frame_q  <= '0;
      rx_fields_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx_shift <= {bus.tx_data[FRAME_W-2:0], 1'b0};
            mosi_q   <= bus.tx_data[FRAME_W-1];
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        XFER: begin
          if (rise_stb) begin
            rx_shift <= {rx_shift[FRAME_W-2:0], bus.miso};
            bit_cnt  <= bit_cnt + 6'd1;
          end
          if (fall_stb) begin
            if (bit_cnt < FRAME_BITS) begin
              tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
              mosi_q   <= tx_shift[FRAME_W-1];
            end else begin
              mosi_q <= 1'b0;
              cnt    <= '0;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cs_q        <= 1'b1;
            rx_frame_q  <= rx_shift;
            rx_fields_q <= unpack_frame(rx_shift);
            rx_valid_q  <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_w;
  assign bus.mosi     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_frame = rx_frame_q;
  assign bus.rx_x     = rx_fields_q.x;
  assign bus.rx_y     = rx_fields_q.y;
  assign bus.rx_etc   = rx_fields_q.etc;

endmodule
